neuron_train_sched: RTL
=======================

Name: neuron_train_sched

Overview:
- Sequencer that owns one neuron_learn instance and runs supervised training on it.
- Accepts a burst of training samples into a local buffer and runs a seeding phase: neuron valid=0, so its parameters get pseudo-random values.
- Then replays the buffer for epochs with learn=1, accumulating per-epoch absolute output error.
- Stops on convergence, on the epoch limit, or on abort. Sits between the host/test harness and the neuron datapath.

Parameters:
- N, 16, neuron fan-in; must match the driven neuron_learn.
- DEPTH, 8, sample buffer entries (power of two, >=2).
- SEED_CYCLES, 4, trigger pulses issued with n_valid=0 before the first epoch.
- SETTLE, 2, cycles between a trigger pulse and sampling n_out (>=1).
- MAX_EPOCHS, 255, epoch limit; epoch_cnt width EW = $clog2(MAX_EPOCHS+1).
- ERR_THRESH, 4, convergence threshold on epoch_err, in zero2one_t LSBs.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled in IDLE/DONE only.
- abort  in  1  terminate the current run.
- smp_valid  in  1  sample offered.
- smp_ready  out  1  buffer accepts a sample.
- smp_last  in  1  final sample of burst (qualified by smp_valid&&smp_ready).
- smp_in  in  N x zero2one_t  sample inputs.
- smp_expected  in  zero2one_t  sample target.
- n_trigger  out  1  one-cycle pulse to neuron _trigger.
- n_valid  out  1  to neuron valid.
- n_learn  out  1  to neuron learn.
- n_in  out  N x zero2one_t  to neuron in.
- n_expected_out  out  zero2one_t  to neuron expected_out.
- n_out  in  zero2one_t  neuron output.
- busy  out  1  not IDLE/DONE.
- done  out  1  run finished, held until next start.
- converged  out  1  valid with done.
- epoch_cnt  out  EW  completed epochs.
- epoch_err  out  ZW+$clog2(DEPTH)  error of last completed epoch; ZW = $bits(zero2one_t).

Behaviour:
- Reset: state IDLE. smp_ready, n_trigger, n_valid, n_learn, busy, done and converged are 0. epoch_cnt=0, epoch_err=0, n_in and n_expected_out all-zero. Buffer count=0.
- IDLE/DONE + start: go to LOAD, clear count, epoch_cnt, epoch_err, done and converged.
- LOAD:
  - smp_ready=1 while count<DEPTH; a handshake writes buf[count] and increments count.
  - smp_last accepted, or count reaching DEPTH: go to SEED.
  - LOAD with count==0 and smp_last never seen: stays in LOAD.
- SEED:
  - n_valid=0, n_learn=0.
  - Issue SEED_CYCLES trigger pulses, each followed by one idle cycle; n_in/n_expected_out driven from buf[0].
  - Then go to TRAIN with idx=0 and acc=0.
- TRAIN, per sample:
  - Cycle 0: drive n_in=buf[idx].in and n_expected_out=buf[idx].exp, with n_valid=1 and n_learn=1.
  - Cycle 1: n_trigger=1.
  - Wait SETTLE cycles, then acc += |buf[idx].exp - n_out|, unsigned, width ZW+$clog2(DEPTH), no overflow possible.
  - Sample period = 2+SETTLE cycles.
  - idx==count-1 goes to EVAL, otherwise idx++.
- EVAL, one cycle:
  - epoch_err<=acc; epoch_cnt++ (saturating at MAX_EPOCHS).
  - acc<=ERR_THRESH*count: DONE with converged=1.
  - Else if epoch_cnt+1==MAX_EPOCHS: DONE with converged=0.
  - Else TRAIN with idx=0, acc=0.
- DONE: done=1, busy=0, n_valid=0, n_learn=0, n_trigger=0. Buffer is retained, but the next start reloads it.
- abort in any busy state: next cycle enters DONE with converged=0. epoch_err and epoch_cnt keep their last values. A trigger pulse asserted in the same cycle still completes (one cycle).
- start while busy is ignored. start and abort together in IDLE: abort wins, giving DONE with converged=0.
- n_trigger is never high two consecutive cycles. n_in is stable from one cycle before the trigger until SETTLE cycles after it.
- rst mid-run: immediate return to reset values. The neuron's parameters are not touched.

Optional Feature:
- NEURON_SCHED_SHUFFLE_EN defined:
  - An 8-bit Galois LFSR (taps 8,6,5,4; seed 8'hA5 at reset) advances once per EVAL.
  - Each epoch starts at idx = lfsr mod count and wraps modulo count, visiting every sample exactly once.
- Undefined: every epoch starts at idx 0 and the LFSR is absent.

Test Plan:
- Reset values: rst 2 cycles -> busy=0, done=0, smp_ready=0, epoch_cnt=0, n_trigger=0.
- Load and seed: start, then 3 samples with smp_last on the 3rd -> smp_ready drops. Next, 4 trigger pulses with n_valid=0, spaced 2 cycles apart. First TRAIN trigger follows, with n_in=sample 0.
- Convergence on the first epoch: DEPTH=8 full load, stub n_out=expected -> EVAL gives epoch_err=0. done=1, converged=1, epoch_cnt=1; total TRAIN cycles = 8*(2+SETTLE)=32.
- Epoch limit: MAX_EPOCHS=3, stub n_out=expected^8'h80 on 2 samples -> epoch_err=256 each epoch. done after epoch_cnt=3, converged=0.
- Abort and start corner cases:
  - abort mid-TRAIN at idx 2 -> next cycle done=1, converged=0, n_valid=0, no further triggers.
  - start during TRAIN -> ignored.
- Shuffle (macro defined): 4 samples -> epoch 2 starts at idx = lfsr(1 step from A5) mod 4. Each sample is presented exactly once per epoch.

Source files
------------

// File: rtl/neuron_train_sched.sv
// Supervised-training sequencer for one neuron_learn: buffers a sample burst, seeds the
// neuron, then replays epochs with learning. Optional macro NEURON_SCHED_SHUFFLE_EN.
module neuron_train_sched #(
    parameter int N           = 16,
    parameter int DEPTH       = 8,
    parameter int SEED_CYCLES = 4,
    parameter int SETTLE      = 2,
    parameter int MAX_EPOCHS  = 255,
    parameter int ERR_THRESH  = 4,
    parameter int ZW          = 8,
    localparam int EW         = $clog2(MAX_EPOCHS + 1),
    localparam int AW         = ZW + $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            smp_valid,
    output logic            smp_ready,
    input  logic            smp_last,
    input  logic [N*ZW-1:0] smp_in,
    input  logic [ZW-1:0]   smp_expected,
    output logic            n_trigger,
    output logic            n_valid,
    output logic            n_learn,
    output logic [N*ZW-1:0] n_in,
    output logic [ZW-1:0]   n_expected_out,
    input  logic [ZW-1:0]   n_out,
    output logic            busy,
    output logic            done,
    output logic            converged,
    output logic [EW-1:0]   epoch_cnt,
    output logic [AW-1:0]   epoch_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = $clog2(SETTLE + 2);
    localparam int SW = $clog2(SEED_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEED,
        S_TRAIN,
        S_EVAL,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     pos_q, pos_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic [SW-1:0]     seed_q, seed_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [EW-1:0]     ecnt_q, ecnt_d;
    logic [AW-1:0]     eerr_q, eerr_d;
    logic              conv_q, conv_d;
    logic [N*ZW-1:0]   nin_q, nin_d;
    logic [ZW-1:0]     nexp_q, nexp_d;
    logic              wr_en;
    logic [ZW-1:0]     abs_err;

    logic [N*ZW-1:0]   mem_in  [DEPTH];
    logic [ZW-1:0]     mem_exp [DEPTH];

`ifdef NEURON_SCHED_SHUFFLE_EN
    logic [7:0]        lfsr_q, lfsr_d;
`endif

    assign busy      = (state_q == S_LOAD) || (state_q == S_SEED) ||
                       (state_q == S_TRAIN) || (state_q == S_EVAL);
    assign done      = (state_q == S_DONE);
    assign converged = conv_q;
    assign epoch_cnt = ecnt_q;
    assign epoch_err = eerr_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        pos_d          = pos_q;
        phase_d        = phase_q;
        seed_d         = seed_q;
        acc_d          = acc_q;
        ecnt_d         = ecnt_q;
        eerr_d         = eerr_q;
        conv_d         = conv_q;
        nin_d          = nin_q;
        nexp_d         = nexp_q;
        smp_ready      = 1'b0;
        wr_en          = 1'b0;
        n_trigger      = 1'b0;
        n_valid        = 1'b0;
        n_learn        = 1'b0;
        n_in           = nin_q;
        n_expected_out = nexp_q;
        abs_err        = '0;
`ifdef NEURON_SCHED_SHUFFLE_EN
        lfsr_d         = lfsr_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && abort) begin
                    state_d = S_DONE;
                    conv_d  = 1'b0;
                end else if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    ecnt_d  = '0;
                    eerr_d  = '0;
                    conv_d  = 1'b0;
                end
            end
            S_LOAD: begin
                smp_ready = (32'(cnt_q) < DEPTH);
                wr_en     = smp_valid && smp_ready;
                // Show entry 0 (bypassing the write for the first sample) so n_in is
                // already settled in the cycle before the first seed trigger.
                n_in           = (cnt_q == '0) ? smp_in : mem_in[0];
                n_expected_out = (cnt_q == '0) ? smp_expected : mem_exp[0];
                nin_d          = n_in;
                nexp_d         = n_expected_out;
                if (wr_en) begin
                    cnt_d = cnt_q + 1'b1;
                    if (smp_last || (32'(cnt_q) + 1 == DEPTH)) begin
                        state_d = S_SEED;
                        phase_d = '0;
                        seed_d  = '0;
                    end
                end
            end
            S_SEED: begin
                n_in           = mem_in[0];
                n_expected_out = mem_exp[0];
                nin_d          = n_in;
                nexp_d         = n_expected_out;
                n_trigger      = (phase_q == '0);
                if (phase_q == '0) begin
                    phase_d = PW'(1);
                end else begin
                    phase_d = '0;
                    if (32'(seed_q) == SEED_CYCLES - 1) begin
                        state_d = S_TRAIN;
                        pos_d   = '0;
                        acc_d   = '0;
`ifdef NEURON_SCHED_SHUFFLE_EN
                        idx_d   = IW'(lfsr_q % 8'(cnt_q));
`else
                        idx_d   = '0;
`endif
                    end else begin
                        seed_d = seed_q + 1'b1;
                    end
                end
            end
            S_TRAIN: begin
                n_in           = mem_in[idx_q];
                n_expected_out = mem_exp[idx_q];
                nin_d          = n_in;
                nexp_d         = n_expected_out;
                n_valid        = 1'b1;
                n_learn        = 1'b1;
                n_trigger      = (32'(phase_q) == 1);
                if (32'(phase_q) == SETTLE + 1) begin
                    abs_err = (mem_exp[idx_q] >= n_out) ? (mem_exp[idx_q] - n_out)
                                                        : (n_out - mem_exp[idx_q]);
                    acc_d   = acc_q + AW'(abs_err);
                    phase_d = '0;
                    // pos counts visits; idx wraps so a shuffled start still covers all entries
                    if (32'(pos_q) == 32'(cnt_q) - 1) begin
                        state_d = S_EVAL;
                    end else begin
                        pos_d = pos_q + 1'b1;
                        idx_d = (32'(idx_q) == 32'(cnt_q) - 1) ? '0 : idx_q + 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_EVAL: begin
                eerr_d = acc_q;
                if (32'(ecnt_q) < MAX_EPOCHS) ecnt_d = ecnt_q + 1'b1;
`ifdef NEURON_SCHED_SHUFFLE_EN
                lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
`endif
                if (32'(acc_q) <= ERR_THRESH * 32'(cnt_q)) begin
                    state_d = S_DONE;
                    conv_d  = 1'b1;
                end else if (32'(ecnt_q) + 1 == MAX_EPOCHS) begin
                    state_d = S_DONE;
                    conv_d  = 1'b0;
                end else begin
                    state_d = S_TRAIN;
                    pos_d   = '0;
                    acc_d   = '0;
                    phase_d = '0;
`ifdef NEURON_SCHED_SHUFFLE_EN
                    idx_d   = IW'(lfsr_d % 8'(cnt_q));
`else
                    idx_d   = '0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort && busy) begin
            state_d = S_DONE;
            conv_d  = 1'b0;
            eerr_d  = eerr_q;
            ecnt_d  = ecnt_q;
`ifdef NEURON_SCHED_SHUFFLE_EN
            lfsr_d  = lfsr_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            pos_q   <= '0;
            phase_q <= '0;
            seed_q  <= '0;
            acc_q   <= '0;
            ecnt_q  <= '0;
            eerr_q  <= '0;
            conv_q  <= 1'b0;
            nin_q   <= '0;
            nexp_q  <= '0;
`ifdef NEURON_SCHED_SHUFFLE_EN
            lfsr_q  <= 8'hA5;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            phase_q <= phase_d;
            seed_q  <= seed_d;
            acc_q   <= acc_d;
            ecnt_q  <= ecnt_d;
            eerr_q  <= eerr_d;
            conv_q  <= conv_d;
            nin_q   <= nin_d;
            nexp_q  <= nexp_d;
`ifdef NEURON_SCHED_SHUFFLE_EN
            lfsr_q  <= lfsr_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_in[cnt_q[IW-1:0]]  <= smp_in;
            mem_exp[cnt_q[IW-1:0]] <= smp_expected;
        end
    end

endmodule
